// File: rtl/reg_commit_ctrl_pkg.sv
// Shared constants and FSM encoding for the in-order retirement controller.
package reg_commit_ctrl_pkg;

  localparam int REG_SIZE   = 32;
  localparam int REG_WIDTH  = $clog2(REG_SIZE);
  localparam int ROB_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;

  localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WALK = 2'd1,
    ST_HALT = 2'd2
  } commit_state_e;

endpackage

// File: rtl/reg_commit_ctrl_if.sv
// ROB-head / register-file bundle; master is the commit controller side.
interface reg_commit_ctrl_if #(
  parameter int REG_W  = 5,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32
);
  logic              rob_head_valid;
  logic              rob_head_ready;
  logic [ROB_W-1:0]  rob_head_tag;
  logic [REG_W-1:0]  rob_head_rd;
  logic [DATA_W-1:0] rob_head_value;
  logic              rob_head_mispred;
  logic              rob_head_halt;
  logic              rob_pop;
  logic [REG_W-1:0]  rf_reg_index;
  logic [ROB_W-1:0]  rf_entry_tag;
  logic [DATA_W-1:0] rf_new_value;
  logic              rf_clear_ena;
  logic [REG_W-1:0]  rf_clear_index;
  logic              flush_out;
  logic              stall_decode;
  logic              halted;

  modport master (
    input  rob_head_valid, rob_head_ready, rob_head_tag, rob_head_rd,
           rob_head_value, rob_head_mispred, rob_head_halt,
    output rob_pop, rf_reg_index, rf_entry_tag, rf_new_value,
           rf_clear_ena, rf_clear_index, flush_out, stall_decode, halted
  );

  modport slave (
    output rob_head_valid, rob_head_ready, rob_head_tag, rob_head_rd,
           rob_head_value, rob_head_mispred, rob_head_halt,
    input  rob_pop, rf_reg_index, rf_entry_tag, rf_new_value,
           rf_clear_ena, rf_clear_index, flush_out, stall_decode, halted
  );
endinterface

// File: rtl/reg_commit_ctrl_flush_walker.sv
// Post-flush register walk: clears busy/tag of registers 1..REG_SIZE-1, one per cycle.
module reg_commit_ctrl_flush_walker #(
  parameter int REG_SIZE = 32,
  parameter int IDX_W    = $clog2(REG_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             clear_ena,
  output logic [IDX_W-1:0] clear_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_SIZE - 1);

  logic [IDX_W-1:0] walk_idx;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      walk_idx <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      walk_idx <= IDX_W'(1);
    end else if (busy) begin
      if (walk_idx == LAST_IDX) begin
        busy     <= 1'b0;
        walk_idx <= '0;
      end else begin
        walk_idx <= walk_idx + IDX_W'(1);
      end
    end
  end

  assign clear_ena   = busy;
  assign clear_index = walk_idx;

endmodule

// File: rtl/reg_commit_ctrl.sv
// In-order retirement controller: ROB head -> register file write port, flush + register walk.
// Optional retired-instruction counter enabled by defining COMMIT_CNT_EN.
module reg_commit_ctrl
  import reg_commit_ctrl_pkg::*;
#(
  parameter int REG_SIZE = reg_commit_ctrl_pkg::REG_SIZE,
  parameter int ROB_W    = ROB_WIDTH,
  parameter int DATA_W   = DATA_WIDTH
) (
  input  logic clk,
  input  logic rst,
  reg_commit_ctrl_if.master bus
`ifdef COMMIT_CNT_EN
  ,
  output logic [31:0] commit_count
`endif
);

  localparam int               IDX_W    = $clog2(REG_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_SIZE - 1);

  commit_state_e     state, state_nxt;
  logic              pop;
  logic              flush_q;
  logic              walk_busy;
  logic              walk_last;
  logic [IDX_W-1:0]  walk_index;
  logic [IDX_W-1:0]  wr_index;
  logic [ROB_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_value;

  // The walk starts on the flush cycle itself, so clearing begins the cycle after flush_out.
  reg_commit_ctrl_flush_walker #(.REG_SIZE(REG_SIZE)) u_walker (
    .clk         (clk),
    .rst         (rst),
    .start       (flush_q),
    .busy        (walk_busy),
    .clear_ena   (bus.rf_clear_ena),
    .clear_index (walk_index)
  );

  assign walk_last          = walk_busy && (walk_index == LAST_IDX);
  assign bus.rf_clear_index = walk_index;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (pop) begin
          if (bus.rob_head_halt)         state_nxt = ST_HALT;
          else if (bus.rob_head_mispred) state_nxt = ST_WALK;
        end
      end
      ST_WALK: if (walk_last) state_nxt = ST_RUN;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    pop              = 1'b0;
    bus.stall_decode = flush_q;
    bus.halted       = 1'b0;
    case (state)
      ST_RUN:  pop              = bus.rob_head_valid & bus.rob_head_ready;
      ST_WALK: bus.stall_decode = 1'b1;
      ST_HALT: bus.halted       = 1'b1;
      default: ;
    endcase
  end

  assign bus.rob_pop = pop;

  // Halt outranks mispredict: a halting branch never flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q  <= 1'b0;
      wr_index <= '0;
      wr_tag   <= ROB_W'(ZERO_ROB);
      wr_value <= '0;
    end else begin
      flush_q <= pop & bus.rob_head_mispred & ~bus.rob_head_halt;
      if (pop) begin
        wr_index <= bus.rob_head_rd;
        wr_tag   <= bus.rob_head_tag;
        wr_value <= bus.rob_head_value;
      end else begin
        wr_index <= '0;
        wr_tag   <= ROB_W'(ZERO_ROB);
      end
    end
  end

  assign bus.flush_out    = flush_q;
  assign bus.rf_reg_index = wr_index;
  assign bus.rf_entry_tag = wr_tag;
  assign bus.rf_new_value = wr_value;

`ifdef COMMIT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      commit_count <= '0;
    else if (pop) commit_count <= commit_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_reg_commit_ctrl.sv
// Directed self-checking bench for reg_commit_ctrl (build with or without COMMIT_CNT_EN).
module tb_reg_commit_ctrl;
  import reg_commit_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_commit_ctrl_if #(.REG_W(REG_WIDTH), .ROB_W(ROB_WIDTH), .DATA_W(DATA_WIDTH)) bus ();

`ifdef COMMIT_CNT_EN
  logic [31:0] commit_count;
`endif

  reg_commit_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef COMMIT_CNT_EN
    ,
    .commit_count (commit_count)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change #1 after a rising edge; outputs are sampled #1 later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic v, input logic r, input logic [4:0] rd,
                          input logic [3:0] tag, input logic [31:0] val,
                          input logic mis, input logic hlt);
    bus.rob_head_valid   = v;
    bus.rob_head_ready   = r;
    bus.rob_head_rd      = rd;
    bus.rob_head_tag     = tag;
    bus.rob_head_value   = val;
    bus.rob_head_mispred = mis;
    bus.rob_head_halt    = hlt;
    #1;
  endtask

  task automatic do_reset();
    set_head(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    set_head(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) next_cycle();
    n_checks++;
    if ({bus.rob_pop, bus.rf_reg_index, bus.rf_entry_tag, bus.rf_new_value, bus.rf_clear_ena,
         bus.rf_clear_index, bus.flush_out, bus.stall_decode, bus.halted} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: pop=%0b idx=%0d tag=%0d val=%h clr=%0b cidx=%0d flush=%0b stall=%0b halted=%0b, all must be 0",
               bus.rob_pop, bus.rf_reg_index, bus.rf_entry_tag, bus.rf_new_value, bus.rf_clear_ena,
               bus.rf_clear_index, bus.flush_out, bus.stall_decode, bus.halted);
    end
`ifdef COMMIT_CNT_EN
    n_checks++;
    if (commit_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", commit_count);
    end
`endif
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single_pop();
    set_head(1, 1, 5'd5, 4'd3, 32'hDEADBEEF, 0, 0);
    n_checks++;
    if (bus.rob_pop !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pop_comb: rob_pop=%0b expected 1", bus.rob_pop);
    end
    next_cycle();
    set_head(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (bus.rf_reg_index !== 5'd5 || bus.rf_entry_tag !== 4'd3 || bus.rf_new_value !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_pop_write: idx=%0d tag=%0d val=%h expected 5/3/deadbeef",
               bus.rf_reg_index, bus.rf_entry_tag, bus.rf_new_value);
    end
    next_cycle();
    n_checks++;
    if (bus.rf_reg_index !== 5'd0) begin
      n_fail++;
      $display("FAIL single_pop_idle: idx=%0d expected 0", bus.rf_reg_index);
    end
  endtask

  task automatic test_not_ready();
    int pops = 0;
    set_head(1, 0, 5'd7, 4'd6, 32'h1234_5678, 0, 0);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (bus.rob_pop !== 1'b0 || bus.rf_reg_index !== 5'd0) begin
        n_fail++;
        $display("FAIL not_ready_c%0d: pop=%0b idx=%0d expected 0/0", c, bus.rob_pop, bus.rf_reg_index);
      end
      next_cycle();
    end
    set_head(1, 1, 5'd7, 4'd6, 32'h1234_5678, 0, 0);
    if (bus.rob_pop === 1'b1) pops++;
    next_cycle();
    set_head(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      if (bus.rob_pop === 1'b1) pops++;
      next_cycle();
    end
    n_checks++;
    if (pops != 1) begin
      n_fail++;
      $display("FAIL not_ready_popcount: pops=%0d expected 1", pops);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_idx;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_head(1, 1, 5'(i), 4'(i), 32'(i * 32'h11), 0, 0);
      n_checks++;
      if (bus.rob_pop !== 1'b1 || (i > 1 && bus.rf_reg_index !== 5'(i - 1))) begin
        n_fail++;
        $display("FAIL b2b_%0d: pop=%0b idx=%0d expected 1/%0d", i, bus.rob_pop, bus.rf_reg_index, i - 1);
      end
      next_cycle();
    end
    set_head(0, 0, 0, 0, 0, 0, 0);
    exp_idx = 5'd4;
    n_checks++;
    if (bus.rf_reg_index !== exp_idx || bus.rf_new_value !== 32'h44) begin
      n_fail++;
      $display("FAIL b2b_last: idx=%0d val=%h expected 4/44", bus.rf_reg_index, bus.rf_new_value);
    end
`ifdef COMMIT_CNT_EN
    n_checks++;
    if (commit_count !== 32'd4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 4", commit_count);
    end
`endif
    next_cycle();
  endtask

  task automatic test_mispred();
    set_head(1, 1, 5'd1, 4'd9, 32'hCAFE_0001, 1, 0);
    next_cycle();
    // Head stays ready with mispred cleared: nothing may pop during flush/walk.
    set_head(1, 1, 5'd2, 4'd10, 32'hCAFE_0002, 0, 0);
    n_checks++;
    if (bus.rf_reg_index !== 5'd1 || bus.flush_out !== 1'b1 || bus.stall_decode !== 1'b1 ||
        bus.rob_pop !== 1'b0 || bus.rf_clear_ena !== 1'b0) begin
      n_fail++;
      $display("FAIL mispred_flush: idx=%0d flush=%0b stall=%0b pop=%0b clr=%0b expected 1/1/1/0/0",
               bus.rf_reg_index, bus.flush_out, bus.stall_decode, bus.rob_pop, bus.rf_clear_ena);
    end
    for (int k = 1; k <= 31; k++) begin
      next_cycle();
      n_checks++;
      if (bus.rf_clear_ena !== 1'b1 || bus.rf_clear_index !== 5'(k) || bus.stall_decode !== 1'b1 ||
          bus.rob_pop !== 1'b0 || bus.flush_out !== 1'b0) begin
        n_fail++;
        $display("FAIL walk_%0d: clr=%0b cidx=%0d stall=%0b pop=%0b flush=%0b expected 1/%0d/1/0/0",
                 k, bus.rf_clear_ena, bus.rf_clear_index, bus.stall_decode, bus.rob_pop, bus.flush_out, k);
      end
    end
    next_cycle();
    n_checks++;
    if (bus.rob_pop !== 1'b1 || bus.rf_clear_ena !== 1'b0 || bus.stall_decode !== 1'b0) begin
      n_fail++;
      $display("FAIL mispred_resume: pop=%0b clr=%0b stall=%0b expected 1/0/0",
               bus.rob_pop, bus.rf_clear_ena, bus.stall_decode);
    end
    next_cycle();
    set_head(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (bus.rf_reg_index !== 5'd2 || bus.rf_entry_tag !== 4'd10) begin
      n_fail++;
      $display("FAIL mispred_resume_write: idx=%0d tag=%0d expected 2/10", bus.rf_reg_index, bus.rf_entry_tag);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_walk();
    set_head(1, 1, 5'd3, 4'd1, 32'h0000_0033, 1, 0);
    next_cycle();
    set_head(0, 0, 0, 0, 0, 0, 0);
    repeat (10) next_cycle();
    n_checks++;
    if (bus.rf_clear_ena !== 1'b1 || bus.rf_clear_index !== 5'd10) begin
      n_fail++;
      $display("FAIL midwalk_pos: clr=%0b cidx=%0d expected 1/10", bus.rf_clear_ena, bus.rf_clear_index);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.rob_pop, bus.rf_reg_index, bus.rf_clear_ena, bus.rf_clear_index,
         bus.flush_out, bus.stall_decode, bus.halted} !== '0) begin
      n_fail++;
      $display("FAIL midwalk_async: pop=%0b idx=%0d clr=%0b cidx=%0d flush=%0b stall=%0b halted=%0b, all must be 0",
               bus.rob_pop, bus.rf_reg_index, bus.rf_clear_ena, bus.rf_clear_index,
               bus.flush_out, bus.stall_decode, bus.halted);
    end
    next_cycle();
    rst = 1'b0;
    set_head(1, 1, 5'd9, 4'd2, 32'h0000_0099, 0, 0);
    n_checks++;
    if (bus.rob_pop !== 1'b1) begin
      n_fail++;
      $display("FAIL midwalk_repop: pop=%0b expected 1", bus.rob_pop);
    end
    next_cycle();
    set_head(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (bus.rf_reg_index !== 5'd9) begin
      n_fail++;
      $display("FAIL midwalk_write: idx=%0d expected 9", bus.rf_reg_index);
    end
    next_cycle();
  endtask

  task automatic test_halt();
    set_head(1, 1, 5'd2, 4'd5, 32'h0000_00AA, 1, 1);
    next_cycle();
    set_head(1, 1, 5'd4, 4'd6, 32'h0000_00BB, 0, 0);
    n_checks++;
    if (bus.halted !== 1'b1 || bus.flush_out !== 1'b0 || bus.rf_reg_index !== 5'd2 || bus.stall_decode !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_entry: halted=%0b flush=%0b idx=%0d stall=%0b expected 1/0/2/0",
               bus.halted, bus.flush_out, bus.rf_reg_index, bus.stall_decode);
    end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      n_checks++;
      if (bus.rob_pop !== 1'b0 || bus.halted !== 1'b1 || bus.rf_reg_index !== 5'd0 || bus.rf_clear_ena !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_hold_%0d: pop=%0b halted=%0b idx=%0d clr=%0b expected 0/1/0/0",
                 c, bus.rob_pop, bus.halted, bus.rf_reg_index, bus.rf_clear_ena);
      end
    end
    do_reset();
    n_checks++;
    if (bus.halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset: halted=%0b expected 0", bus.halted);
    end
  endtask

  initial begin
    set_head(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_single_pop();
    test_not_ready();
    test_back_to_back();
    test_mispred();
    test_reset_mid_walk();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
